// File: rtl/axi_pkg.sv
// Shared AXI definitions: bus width macros, response and burst encodings,
// and the state types used by the default slave FSMs.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS  8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS  4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_pkg;

    // Response encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // Read channel FSM states
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_t;

    // Write channel FSM states
    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_DATA = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

endpackage

// File: rtl/axi_default_slave.sv
// Default AXI4 slave: terminates every read and write burst that decodes
// outside the memory windows with a DECERR response so stray accesses
// cannot stall the interconnect. Read and write sides run independently.

`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS  8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS  4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_default_slave
    import axi_pkg::*;
#(
    parameter logic [`AXI_DATA_BITS-1:0] DEFAULT_RDATA = 32'h0000_0000
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,

    // Read address channel
    input  logic [`AXI_IDS_BITS-1:0]   ARID_S,
    input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]   ARLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S,
    input  logic [1:0]                 ARBURST_S,
    input  logic                       ARVALID_S,
    output logic                       ARREADY_S,

    // Read data channel
    output logic [`AXI_IDS_BITS-1:0]   RID_S,
    output logic [`AXI_DATA_BITS-1:0]  RDATA_S,
    output logic [1:0]                 RRESP_S,
    output logic                       RLAST_S,
    output logic                       RVALID_S,
    input  logic                       RREADY_S,

    // Write address channel
    input  logic [`AXI_IDS_BITS-1:0]   AWID_S,
    input  logic [`AXI_ADDR_BITS-1:0]  AWADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]   AWLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE_S,
    input  logic [1:0]                 AWBURST_S,
    input  logic                       AWVALID_S,
    output logic                       AWREADY_S,

    // Write data channel
    input  logic [`AXI_DATA_BITS-1:0]  WDATA_S,
    input  logic [`AXI_STRB_BITS-1:0]  WSTRB_S,
    input  logic                       WLAST_S,
    input  logic                       WVALID_S,
    output logic                       WREADY_S,

    // Write response channel
    output logic [`AXI_IDS_BITS-1:0]   BID_S,
    output logic [1:0]                 BRESP_S,
    output logic                       BVALID_S,
    input  logic                       BREADY_S
);

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    rd_state_t                 rd_state;
    rd_state_t                 rd_state_nxt;
    logic [`AXI_IDS_BITS-1:0]  rid;
    logic [`AXI_LEN_BITS-1:0]  rlen;
    logic [`AXI_LEN_BITS-1:0]  cnt;
    logic                      ar_hs;
    logic                      r_hs;
    logic                      r_last_beat;

    assign ar_hs       = (rd_state == R_IDLE) && ARVALID_S;
    assign r_hs        = (rd_state == R_DATA) && RREADY_S;
    assign r_last_beat = (cnt == rlen);

    // Read FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state <= R_IDLE;
        end else begin
            rd_state <= rd_state_nxt;
        end
    end

    // Read FSM next-state decode: leave idle on AR, return after last beat
    always_comb begin
        rd_state_nxt = rd_state;
        case (rd_state)
            R_IDLE: if (ARVALID_S) rd_state_nxt = R_DATA;
            R_DATA: if (RREADY_S && r_last_beat) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Read burst fields: capture ID/length on AR, count accepted beats
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rid  <= '0;
            rlen <= '0;
            cnt  <= '0;
        end else if (ar_hs) begin
            rid  <= ARID_S;
            rlen <= ARLEN_S;
            cnt  <= '0;
        end else if (r_hs) begin
            cnt  <= cnt + 1'b1;
        end
    end

    // Read channel outputs decoded purely from registered state
    always_comb begin
        ARREADY_S = 1'b0;
        RVALID_S  = 1'b0;
        RLAST_S   = 1'b0;
        case (rd_state)
            R_IDLE: ARREADY_S = 1'b1;
            R_DATA: begin
                RVALID_S = 1'b1;
                RLAST_S  = r_last_beat;
            end
            default: ARREADY_S = 1'b0;
        endcase
    end

    assign RID_S   = rid;
    assign RDATA_S = DEFAULT_RDATA;
    assign RRESP_S = RESP_DECERR;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_t                 wr_state;
    wr_state_t                 wr_state_nxt;
    logic [`AXI_IDS_BITS-1:0]  bid;
    logic                      aw_hs;

    assign aw_hs = (wr_state == W_IDLE) && AWVALID_S;

    // Write FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state <= W_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
        end
    end

    // Write FSM next-state decode: AW, then W until WLAST, then B
    always_comb begin
        wr_state_nxt = wr_state;
        case (wr_state)
            W_IDLE: if (AWVALID_S) wr_state_nxt = W_DATA;
            W_DATA: if (WVALID_S && WLAST_S) wr_state_nxt = W_RESP;
            W_RESP: if (BREADY_S) wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    // Write ID capture, held for the B response
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            bid <= '0;
        end else if (aw_hs) begin
            bid <= AWID_S;
        end
    end

    // Write channel outputs decoded purely from registered state;
    // WREADY stays low outside W_DATA so W beats cannot overtake AW
    always_comb begin
        AWREADY_S = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        case (wr_state)
            W_IDLE: AWREADY_S = 1'b1;
            W_DATA: WREADY_S  = 1'b1;
            W_RESP: BVALID_S  = 1'b1;
            default: AWREADY_S = 1'b0;
        endcase
    end

    assign BID_S   = bid;
    assign BRESP_S = RESP_DECERR;

    // Address attributes and write payload are intentionally ignored
    logic unused_inputs;
    assign unused_inputs = ^{ARADDR_S, ARSIZE_S, ARBURST_S,
                             AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S,
                             WDATA_S, WSTRB_S};

endmodule

// File: doc/axi_default_slave.md
# axi_default_slave

AXI4 default slave attached to the crossbar as the target for every address outside the IM and DM windows. It completes every read or write burst it receives with a DECERR response. This keeps a stray CPU fetch or load/store from hanging the bus. It sits directly downstream of the AXI interconnect, alongside the SRAM wrappers, on the slave-side (`AXI_IDS_BITS`) ID width.

## Interface
Parameters:
- DEFAULT_RDATA, 32'h0000_0000: value driven on RDATA_S for every read beat.

Ports:
- Clock and reset: one clock, ACLK; reset ARESETn is asynchronous and active-low.
- ACLK  in  1  clock.
- ARESETn  in  1  async active-low reset.
- ARID_S  in  `AXI_IDS_BITS`  read ID.
- ARADDR_S  in  `AXI_ADDR_BITS`  read address (ignored).
- ARLEN_S  in  `AXI_LEN_BITS`  beats minus one.
- ARSIZE_S  in  `AXI_SIZE_BITS`  ignored.
- ARBURST_S  in  2  ignored.
- ARVALID_S  in  1  AR valid.
- ARREADY_S  out  1  AR ready.
- RID_S  out  `AXI_IDS_BITS`  echoed ARID.
- RDATA_S  out  `AXI_DATA_BITS`  DEFAULT_RDATA.
- RRESP_S  out  2  response.
- RLAST_S  out  1  last beat.
- RVALID_S  out  1  R valid.
- RREADY_S  in  1  R ready.
- AWID_S  in  `AXI_IDS_BITS`  write ID.
- AWADDR_S  in  `AXI_ADDR_BITS`  ignored.
- AWLEN_S  in  `AXI_LEN_BITS`  ignored.
- AWSIZE_S  in  `AXI_SIZE_BITS`  ignored.
- AWBURST_S  in  2  ignored.
- AWVALID_S  in  1  AW valid.
- AWREADY_S  out  1  AW ready.
- WDATA_S  in  `AXI_DATA_BITS`  discarded.
- WSTRB_S  in  `AXI_STRB_BITS`  discarded.
- WLAST_S  in  1  last write beat.
- WVALID_S  in  1  W valid.
- WREADY_S  out  1  W ready.
- BID_S  out  `AXI_IDS_BITS`  echoed AWID.
- BRESP_S  out  2  response.
- BVALID_S  out  1  B valid.
- BREADY_S  in  1  B ready.

## Operation
- The read FSM and the write FSM are fully independent. A read and a write may be in flight at the same time.
- Read FSM states:
  - R_IDLE: ARREADY_S=1. On ARVALID_S, latch ARID_S→rid and ARLEN_S→rlen, clear the beat counter, go to R_DATA.
  - R_DATA: ARREADY_S=0, RVALID_S=1, RLAST_S=(cnt==rlen).
  - Each RVALID_S&RREADY_S handshake increments cnt (`AXI_LEN_BITS` wide, no wrap possible since cnt≤rlen).
  - A handshake with RLAST_S=1 returns to R_IDLE.
- Write FSM states:
  - W_IDLE: AWREADY_S=1. On AWVALID_S, latch AWID_S→bid, go to W_DATA.
  - W_DATA: WREADY_S=1, data discarded. A WVALID_S&WLAST_S handshake goes to W_RESP. Beat count is not checked; WLAST_S alone terminates the burst.
  - W_RESP: BVALID_S=1. BREADY_S returns to W_IDLE.
- W beats arriving before AW (in W_IDLE) are not accepted: WREADY_S=0 outside W_DATA.
- RRESP_S and BRESP_S are constant 2'b11 (DECERR).
- RDATA_S is constant DEFAULT_RDATA.
- Reset values, asserted asynchronously:
  - ARREADY_S=1, AWREADY_S=1.
  - RVALID_S=0, RLAST_S=0, WREADY_S=0, BVALID_S=0.
  - RID_S=0, BID_S=0.
  - RDATA_S=DEFAULT_RDATA, RRESP_S=BRESP_S=2'b11.
- Reset mid-burst: both FSMs return to IDLE immediately and any in-flight transaction is dropped with no response.

## Timing
- All outputs are decoded from registered state and latched fields. There are no combinational paths from inputs to outputs.
- Read path:
  - AR handshake at edge N → RVALID_S=1 from cycle N+1.
  - With RREADY_S held high, one beat per cycle; last beat in cycle N+1+rlen.
  - ARREADY_S=1 again in the cycle after the RLAST handshake, so back-to-back bursts cost one idle R cycle.
- Write path:
  - AW handshake at N → WREADY_S=1 from N+1.
  - WLAST handshake at M → BVALID_S=1 from M+1.
  - B handshake at K → AWREADY_S=1 from K+1.
- Stalls: RVALID_S/BVALID_S stay high and RID_S/RLAST_S/BID_S stay stable while READY is low (AXI hold rule).

## Structure
- Shared package axi_pkg holds:
  - Response constants: RESP_OKAY=2'b00, RESP_DECERR=2'b11.
  - Burst encodings.
  - rd_state_t {R_IDLE,R_DATA} and wr_state_t {W_IDLE,W_DATA,W_RESP}.
- Width macros come from include.svh.
- No sub-module is needed: one module with two independent sequential blocks (read, write).

## Test plan
- Single read: ARID=8'h15, ARLEN=0 with RREADY=1 → one beat one cycle later: RID=8'h15, RDATA=0, RRESP=2'b11, RLAST=1. ARREADY returns to 1 the cycle after.
- Burst read with stalls: ARLEN=3, RREADY toggled 1,0,1,0… → exactly 4 beats, RLAST only on the 4th, outputs stable during stalls.
- Write burst: AWID=8'h22, four W beats with WLAST on the 4th, BREADY held 0 for 3 cycles → BVALID held with BID=8'h22, BRESP=2'b11 until BREADY.
- Concurrent: AR (ARLEN=1) and AW issued in the same cycle → both handshake that cycle, and both complete with correct IDs and no interference.
- Reset mid-operation: ARESETn low during beat 2 of an ARLEN=7 read → RVALID=0 and ARREADY=1 asynchronously. After release, a new ARLEN=0 read completes normally.
- Early W: WVALID asserted before AWVALID → WREADY stays 0 until the cycle after the AW handshake.
